// File: rtl/nirs_scan_sched.sv
// NIRS acquisition scan scheduler: steps through every LED source (plus an optional
// dark slot), waits for settling, drops stale ADC frames and forwards tagged frames.
module nirs_scan_sched #(
  parameter int P_SRC_NUM    = 32,
  parameter int P_SETTLE_CYC = 5000,
  parameter int P_DISCARD    = 2,
  parameter int P_FRAMES     = 4,
  parameter int P_BLANK_CYC  = 500,
  parameter int P_DARK_EN    = 1
) (
  input  logic                 i_sysclk,
  input  logic                 i_rst_n,
  input  logic                 i_scan_en,
  output logic                 o_adc_start,
  output logic [P_SRC_NUM-1:0] o_src_onehot,
  output logic [5:0]           o_src_idx,
  input  logic [191:0]         i_adc_data,
  input  logic                 i_adc_valid,
  output logic                 o_adc_ready,
  output logic [191:0]         o_frame_data,
  output logic [9:0]           o_frame_tag,
  output logic                 o_frame_valid,
  input  logic                 i_frame_ready,
  output logic                 o_scan_done,
  output logic [15:0]          o_scan_cnt,
  output logic                 o_busy
);

  localparam int          NSLOT       = P_SRC_NUM + P_DARK_EN;
  localparam logic [5:0]  LAST_SLOT   = 6'(NSLOT - 1);
  localparam logic [31:0] SETTLE_LAST = 32'(P_SETTLE_CYC - 1);
  localparam logic [31:0] BLANK_LAST  = (P_BLANK_CYC == 0) ? 32'd0 : 32'(P_BLANK_CYC - 1);
  localparam logic [31:0] DISC_LAST   = (P_DISCARD == 0) ? 32'd0 : 32'(P_DISCARD - 1);
  localparam logic [3:0]  FRAME_LAST  = 4'(P_FRAMES - 1);
  localparam logic [P_SRC_NUM-1:0] LED_ONE = {{(P_SRC_NUM-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, SETTLE, DISCARD, ACQ, BLANK, DONE} state_t;

  state_t        state, state_nxt;
  logic [5:0]    slot, slot_nxt;
  logic [31:0]   cnt, cnt_nxt;
  logic [3:0]    fidx, fidx_nxt;
  logic          adc_ready;
  logic          adc_xfer;
  logic          lit;
  logic [191:0]  frame_data;
  logic [9:0]    frame_tag;
  logic          frame_valid;
  logic [15:0]   scan_cnt;

  always_comb begin
    adc_ready = 1'b0;
    case (state)
      IDLE:    adc_ready = 1'b1;
      DISCARD: adc_ready = 1'b1;
      ACQ:     adc_ready = ~frame_valid | i_frame_ready;
      default: adc_ready = 1'b0;
    endcase
  end

  assign adc_xfer = i_adc_valid & adc_ready;

  always_comb begin
    state_nxt = state;
    slot_nxt  = slot;
    cnt_nxt   = cnt;
    fidx_nxt  = fidx;
    case (state)
      IDLE: begin
        // A frame still waiting downstream from an aborted scan must drain first.
        if (i_scan_en && !frame_valid) begin
          state_nxt = SETTLE;
          slot_nxt  = 6'd0;
          cnt_nxt   = 32'd0;
          fidx_nxt  = 4'd0;
        end
      end
      SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          cnt_nxt   = 32'd0;
          state_nxt = (P_DISCARD == 0) ? ACQ : DISCARD;
        end else begin
          cnt_nxt = cnt + 32'd1;
        end
      end
      DISCARD: begin
        if (adc_xfer) begin
          if (cnt == DISC_LAST) begin
            cnt_nxt   = 32'd0;
            state_nxt = ACQ;
          end else begin
            cnt_nxt = cnt + 32'd1;
          end
        end
      end
      ACQ: begin
        if (adc_xfer) begin
          if (fidx == FRAME_LAST) begin
            fidx_nxt  = 4'd0;
            state_nxt = BLANK;
          end else begin
            fidx_nxt = fidx + 4'd1;
          end
        end
      end
      BLANK: begin
        if (cnt == BLANK_LAST) begin
          cnt_nxt = 32'd0;
          if (slot == LAST_SLOT) begin
            state_nxt = DONE;
          end else begin
            slot_nxt  = slot + 6'd1;
            state_nxt = SETTLE;
          end
        end else begin
          cnt_nxt = cnt + 32'd1;
        end
      end
      DONE: begin
        cnt_nxt  = 32'd0;
        fidx_nxt = 4'd0;
        slot_nxt = 6'd0;
        state_nxt = i_scan_en ? SETTLE : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (!i_scan_en && (state inside {SETTLE, DISCARD, ACQ, BLANK})) begin
      state_nxt = IDLE;
      cnt_nxt   = 32'd0;
      fidx_nxt  = 4'd0;
    end
  end

  always_ff @(posedge i_sysclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      slot  <= 6'd0;
      cnt   <= 32'd0;
      fidx  <= 4'd0;
    end else begin
      state <= state_nxt;
      slot  <= slot_nxt;
      cnt   <= cnt_nxt;
      fidx  <= fidx_nxt;
    end
  end

  // Single output register: a new frame loads only while ACQ has room for it.
  always_ff @(posedge i_sysclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      frame_valid <= 1'b0;
      frame_data  <= '0;
      frame_tag   <= '0;
      scan_cnt    <= 16'd0;
    end else begin
      if (state == ACQ && adc_xfer) begin
        frame_valid <= 1'b1;
        frame_data  <= i_adc_data;
        frame_tag   <= {slot, fidx};
      end else if (i_frame_ready) begin
        frame_valid <= 1'b0;
      end
      if (state_nxt == DONE && state != DONE) begin
        scan_cnt <= scan_cnt + 16'd1;
      end
    end
  end

  assign lit           = (state inside {SETTLE, DISCARD, ACQ}) && (slot < 6'(P_SRC_NUM));
  assign o_src_onehot  = lit ? (LED_ONE << slot) : '0;
  assign o_src_idx     = slot;
  assign o_adc_start   = (state != IDLE);
  assign o_busy        = (state != IDLE);
  assign o_scan_done   = (state == DONE);
  assign o_adc_ready   = adc_ready;
  assign o_frame_data  = frame_data;
  assign o_frame_tag   = frame_tag;
  assign o_frame_valid = frame_valid;
  assign o_scan_cnt    = scan_cnt;

endmodule

// File: tb/tb_nirs_scan_sched.sv
// Bench for nirs_scan_sched: randomized ADC source / downstream sink against a
// scoreboard that maps the n-th frame accepted during a scan to its slot and tag.
module tb_nirs_scan_sched;

  localparam int SRC    = 4;
  localparam int SETTLE = 10;
  localparam int DISC   = 2;
  localparam int FR     = 3;
  localparam int BLANK  = 5;
  localparam int DARK   = 1;
  localparam int NSLOT  = SRC + DARK;
  localparam int PER    = DISC + FR;
  localparam int SCAN_CYC = NSLOT * (SETTLE + DISC + FR + BLANK) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          scan_en = 1'b0;
  logic [191:0]  adc_data = '0;
  logic          adc_valid = 1'b0;
  logic          frame_ready = 1'b0;
  logic          adc_start, adc_ready, frame_valid, scan_done, busy;
  logic [SRC-1:0] onehot;
  logic [5:0]    src_idx;
  logic [191:0]  frame_data;
  logic [9:0]    frame_tag;
  logic [15:0]   scan_cnt;

  nirs_scan_sched #(
    .P_SRC_NUM(SRC), .P_SETTLE_CYC(SETTLE), .P_DISCARD(DISC),
    .P_FRAMES(FR), .P_BLANK_CYC(BLANK), .P_DARK_EN(DARK)
  ) dut (
    .i_sysclk(clk), .i_rst_n(rst_n), .i_scan_en(scan_en),
    .o_adc_start(adc_start), .o_src_onehot(onehot), .o_src_idx(src_idx),
    .i_adc_data(adc_data), .i_adc_valid(adc_valid), .o_adc_ready(adc_ready),
    .o_frame_data(frame_data), .o_frame_tag(frame_tag), .o_frame_valid(frame_valid),
    .i_frame_ready(frame_ready), .o_scan_done(scan_done), .o_scan_cnt(scan_cnt),
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [9:0]   tag;
    logic [191:0] data;
  } fr_t;

  fr_t  sbq[$];
  int   n_acc, done_cnt, fwd_cnt, busy_cyc, start_drops, last_done, cyc;
  int   m_slot, m_idx;
  int   src_mode, snk_mode;
  bit   timed, watch_start, prev_busy, adc_xfer_s, prev_hold;
  logic [9:0]    prev_tag;
  logic [191:0]  prev_data;
  logic [SRC-1:0] exp_led;
  fr_t  exp_fr, acc_fr;

  // Monitor / scoreboard, sampled on the falling edge.
  initial begin
    n_acc = 0; done_cnt = 0; fwd_cnt = 0; busy_cyc = 0; start_drops = 0;
    last_done = -1; cyc = 0; timed = 0; watch_start = 0;
    prev_busy = 0; adc_xfer_s = 0; prev_hold = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        sbq.delete();
        n_acc = 0; prev_hold = 0; prev_busy = 0; adc_xfer_s = 0;
      end else begin
        if (busy && !prev_busy) n_acc = 0;
        if (busy) busy_cyc++;
        if (watch_start && !adc_start) start_drops++;
        if (prev_hold) begin
          check_eq("hold_valid", 192'(frame_valid), 192'(1));
          check_eq("hold_tag", 192'(frame_tag), 192'(prev_tag));
          check_eq("hold_data", frame_data, prev_data);
        end
        adc_xfer_s = adc_valid & adc_ready;
        if (adc_xfer_s && busy) begin
          m_slot = n_acc / PER;
          m_idx  = n_acc % PER;
          exp_led = (m_slot < SRC) ? SRC'(1 << m_slot) : '0;
          check_eq("src_idx", 192'(src_idx), 192'(m_slot));
          check_eq("led", 192'(onehot), 192'(exp_led));
          if (m_idx >= DISC) begin
            acc_fr.tag  = {6'(m_slot), 4'(m_idx - DISC)};
            acc_fr.data = adc_data;
            sbq.push_back(acc_fr);
          end
          n_acc++;
        end
        if (frame_valid && frame_ready) begin
          if (sbq.size() > 0) exp_fr = sbq.pop_front();
          else exp_fr = '1;
          check_eq("out_tag", 192'(frame_tag), 192'(exp_fr.tag));
          check_eq("out_data", frame_data, exp_fr.data);
          fwd_cnt++;
        end
        if (scan_done) begin
          check_eq("accepts_per_scan", 192'(n_acc), 192'(NSLOT * PER));
          if (timed && last_done >= 0) check_eq("scan_period", 192'(cyc - last_done), 192'(SCAN_CYC));
          last_done = cyc;
          done_cnt++;
          n_acc = 0;
        end
        prev_hold = frame_valid & ~frame_ready;
        prev_tag  = frame_tag;
        prev_data = frame_data;
        prev_busy = busy;
      end
    end
  end

  // ADC source: holds a frame until accepted.
  initial begin
    forever begin
      @(posedge clk); #2;
      if (src_mode == 2) begin
        adc_valid = 1'b0;
      end else if (!adc_valid || adc_xfer_s) begin
        adc_valid = (src_mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 7);
        adc_data  = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      end
    end
  end

  // Downstream sink.
  initial begin
    forever begin
      @(posedge clk); #2;
      case (snk_mode)
        0:       frame_ready = 1'b1;
        1:       frame_ready = ($urandom_range(0, 3) != 0);
        default: frame_ready = 1'b0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_busy(input bit lvl, input int lim, input string tag);
    int i = 0;
    while (busy !== lvl && i < lim) begin
      @(negedge clk);
      i++;
    end
    check_eq(tag, 192'(busy), 192'(lvl));
  endtask

  // Dropping scan_en during the DONE cycle ends the run cleanly after this scan.
  task automatic wait_done(input int lim, input string tag, input bit drop);
    int i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!scan_done && i < lim);
    check_eq(tag, 192'(scan_done), 192'(1));
    if (drop) scan_en = 1'b0;
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    scan_en = 1'b0;
    #10;
    tick();
    rst_n = 1'b1;
    done_cnt = 0; fwd_cnt = 0; busy_cyc = 0; start_drops = 0; last_done = -1;
  endtask

  task automatic drain_check(input string tag);
    snk_mode = 0;
    repeat (5) @(negedge clk);
    check_eq({tag, "_sb_empty"}, 192'(sbq.size()), 192'(0));
    check_eq({tag, "_valid_clr"}, 192'(frame_valid), 192'(0));
  endtask

  initial begin
    int i;
    src_mode = 0;
    snk_mode = 0;
    repeat (2) @(negedge clk);
    check_eq("rst_led", 192'(onehot), 192'(0));
    check_eq("rst_start", 192'(adc_start), 192'(0));
    check_eq("rst_ready", 192'(adc_ready), 192'(1));
    check_eq("rst_fvalid", 192'(frame_valid), 192'(0));
    check_eq("rst_done", 192'(scan_done), 192'(0));
    check_eq("rst_cnt", 192'(scan_cnt), 192'(0));
    check_eq("rst_busy", 192'(busy), 192'(0));
    check_eq("rst_tag", 192'(frame_tag), 192'(0));
    tick();
    rst_n = 1'b1;

    // Single scan, always-valid source and always-ready sink.
    tick();
    scan_en = 1'b1;
    wait_busy(1'b1, 5, "t1_start");
    wait_done(300, "t1_done", 1'b1);
    wait_busy(1'b0, 5, "t1_idle");
    drain_check("t1");
    check_eq("t1_busy_cycles", 192'(busy_cyc), 192'(SCAN_CYC));
    check_eq("t1_done_cnt", 192'(done_cnt), 192'(1));
    check_eq("t1_fwd_cnt", 192'(fwd_cnt), 192'(NSLOT * FR));
    check_eq("t1_scan_cnt", 192'(scan_cnt), 192'(1));

    // Continuous scanning.
    do_reset();
    timed = 1;
    scan_en = 1'b1;
    wait_busy(1'b1, 5, "t2_start");
    watch_start = 1;
    for (int k = 0; k < 3; k++) wait_done(200, "t2_done", 1'b0);
    watch_start = 0;
    tick();
    @(negedge clk);
    check_eq("t2_scan_cnt", 192'(scan_cnt), 192'(3));
    check_eq("t2_slot0", 192'(src_idx), 192'(0));
    check_eq("t2_led0", 192'(onehot), 192'(1));
    scan_en = 1'b0;
    wait_busy(1'b0, 5, "t2_idle");
    timed = 0;
    check_eq("t2_done_cnt", 192'(done_cnt), 192'(3));
    check_eq("t2_start_drops", 192'(start_drops), 192'(0));
    check_eq("t2_cnt_after_abort", 192'(scan_cnt), 192'(3));
    drain_check("t2");

    // Backpressure during ACQ of slot 1.
    do_reset();
    scan_en = 1'b1;
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!(frame_valid && frame_ready && frame_tag == 10'h010) && i < 200);
    check_eq("t3_reach", 192'(frame_tag), 192'(10'h010));
    tick();
    snk_mode = 2;
    repeat (20) begin
      @(negedge clk);
      check_eq("t3_adc_ready", 192'(adc_ready), 192'(0));
      check_eq("t3_led", 192'(onehot), 192'(4'b0010));
    end
    snk_mode = 0;
    wait_done(300, "t3_done", 1'b1);
    wait_busy(1'b0, 5, "t3_idle");
    drain_check("t3");
    check_eq("t3_fwd_cnt", 192'(fwd_cnt), 192'(NSLOT * FR));

    // Abort mid-DISCARD of slot 2.
    do_reset();
    scan_en = 1'b1;
    i = 0;
    while (!(busy && src_idx == 6'd2) && i < 200) begin
      @(negedge clk);
      i++;
    end
    check_eq("t4_reach", 192'(src_idx), 192'(2));
    src_mode = 2;
    repeat (15) @(negedge clk);
    check_eq("t4_in_discard", 192'(adc_ready), 192'(1));
    check_eq("t4_led", 192'(onehot), 192'(4'b0100));
    scan_en = 1'b0;
    @(negedge clk);
    check_eq("t4_busy", 192'(busy), 192'(0));
    check_eq("t4_led_off", 192'(onehot), 192'(0));
    check_eq("t4_start", 192'(adc_start), 192'(0));
    check_eq("t4_no_done", 192'(done_cnt), 192'(0));
    check_eq("t4_cnt", 192'(scan_cnt), 192'(0));
    src_mode = 0;
    drain_check("t4");

    // Abort while a forwarded frame is pending.
    do_reset();
    scan_en = 1'b1;
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!frame_valid && i < 100);
    check_eq("t5_reach", 192'(frame_valid), 192'(1));
    scan_en = 1'b0;
    snk_mode = 2;
    repeat (5) @(negedge clk);
    check_eq("t5_held", 192'(frame_valid), 192'(1));
    check_eq("t5_tag", 192'(frame_tag), 192'(10'h001));
    check_eq("t5_idle", 192'(busy), 192'(0));
    scan_en = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("t5_blocked", 192'(busy), 192'(0));
    snk_mode = 0;
    wait_busy(1'b1, 10, "t5_restart");
    check_eq("t5_slot0", 192'(src_idx), 192'(0));
    check_eq("t5_led0", 192'(onehot), 192'(1));
    wait_done(300, "t5_done", 1'b1);
    wait_busy(1'b0, 5, "t5_idle2");
    drain_check("t5");
    check_eq("t5_cnt", 192'(scan_cnt), 192'(1));

    // Randomized source/sink, scans back to back, then a random stop.
    for (int r = 0; r < 2; r++) begin
      src_mode = 1;
      snk_mode = 1;
      done_cnt = 0;
      scan_en = 1'b1;
      wait_done(800, "rnd_done", 1'b0);
      wait_done(800, "rnd_done", 1'b0);
      repeat ($urandom_range(1, 120)) @(negedge clk);
      scan_en = 1'b0;
      wait_busy(1'b0, 5, "rnd_idle");
      check_eq("rnd_scans", 192'(done_cnt >= 2), 192'(1));
      drain_check("rnd");
    end

    // Asynchronous reset in the middle of ACQ.
    src_mode = 0;
    snk_mode = 0;
    scan_en = 1'b1;
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!frame_valid && i < 100);
    check_eq("t6_reach", 192'(frame_valid), 192'(1));
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("t6_led", 192'(onehot), 192'(0));
    check_eq("t6_fvalid", 192'(frame_valid), 192'(0));
    check_eq("t6_start", 192'(adc_start), 192'(0));
    check_eq("t6_ready", 192'(adc_ready), 192'(1));
    check_eq("t6_cnt", 192'(scan_cnt), 192'(0));
    check_eq("t6_busy", 192'(busy), 192'(0));
    scan_en = 1'b0;
    #10;
    tick();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("t6_post_idle", 192'(busy), 192'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

endmodule
